// File: rtl/flop_compare_pipe.sv
`default_nettype none
//============================================================================
//  Module      : flop_compare_pipe
//  Description : Two-stage pipelined comparator for a small sign-magnitude
//                floating-point format.
//                  [W-1]          sign
//                  [W-2:MAN_W]    exponent (EXP_W bits)
//                  [MAN_W-1:0]    mantissa (MAN_W bits)
//                The {exp,man} magnitude is compared as one unsigned number.
//                +0 and -0 compare equal. The outputs are gt/eq/lt flags and
//                the larger operand. Valid/ready handshake on both sides,
//                with one pair per cycle throughput.
//                Optional running maximum of consumed results.
//  Ports       : clk           clock, rising edge
//                reset         synchronous active-high reset
//                in_valid      operand pair present
//                in_ready      pipeline accepts the pair this cycle
//                first/second  operands A/B (W bits)
//                out_valid     result present
//                out_ready     downstream consumes the result this cycle
//                gt/eq/lt      A>B, A==B, A<B (one-hot while out_valid)
//                max_out       larger operand (A when equal)
//                max_clear     synchronous clear of the running maximum
//                run_max       running maximum of consumed max_out values
//                run_max_valid run_max holds at least one value
//  Config      : FLOP_CMP_RUNMAX_EN - builds the running-maximum tracker.
//                Without it, run_max/run_max_valid are tied to 0 and
//                max_clear is ignored.
//  Revision    : 1.0 - initial release
//============================================================================
module flop_compare_pipe #(
    parameter  int EXP_W = 4,
    parameter  int MAN_W = 8,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] first,
    input  logic [W-1:0] second,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         gt,
    output logic         eq,
    output logic         lt,
    output logic [W-1:0] max_out,
    input  logic         max_clear,
    output logic [W-1:0] run_max,
    output logic         run_max_valid
);

    localparam int c_MAG_W = EXP_W + MAN_W;

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic r_s1_valid;
    logic r_s2_valid;
    logic w_s2_adv;
    logic w_s1_adv;

    // Stage 2 moves whenever it is empty or being drained; stage 1 can
    // only move when stage 2 makes room for it.
    assign w_s2_adv = ~r_s2_valid | out_ready;
    assign w_s1_adv = w_s2_adv;
    assign in_ready = ~r_s1_valid | w_s1_adv;

    // ------------------------------------------------------------------
    // Stage 1: magnitude compare on the raw operands
    // ------------------------------------------------------------------
    logic [c_MAG_W-1:0] w_mag_a;
    logic [c_MAG_W-1:0] w_mag_b;

    assign w_mag_a = first[c_MAG_W-1:0];
    assign w_mag_b = second[c_MAG_W-1:0];

    logic         r_s1_sign_a;
    logic         r_s1_sign_b;
    logic         r_s1_zero;
    logic         r_s1_mag_gt;
    logic         r_s1_mag_eq;
    logic [W-1:0] r_s1_a;
    logic [W-1:0] r_s1_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
        end
    end

    // Payload registers need no reset: they are qualified by r_s1_valid.
    always_ff @(posedge clk) begin
        if (w_s1_adv && in_valid) begin
            r_s1_sign_a <= first[W-1];
            r_s1_sign_b <= second[W-1];
            r_s1_zero   <= (w_mag_a == '0) && (w_mag_b == '0);
            r_s1_mag_gt <= (w_mag_a > w_mag_b);
            r_s1_mag_eq <= (w_mag_a == w_mag_b);
            r_s1_a      <= first;
            r_s1_b      <= second;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: resolve signs into the final ordering
    // ------------------------------------------------------------------
    logic w_gt;
    logic w_eq;
    logic w_lt;

    always_comb begin
        w_gt = 1'b0;
        w_eq = 1'b0;
        if (r_s1_zero) begin
            // +0 and -0 are the same value
            w_eq = 1'b1;
        end else if (r_s1_sign_a != r_s1_sign_b) begin
            w_gt = ~r_s1_sign_a;
        end else if (r_s1_mag_eq) begin
            w_eq = 1'b1;
        end else begin
            // For two negatives the magnitude ordering is reversed.
            w_gt = r_s1_mag_gt ^ r_s1_sign_a;
        end
    end

    assign w_lt = ~w_gt & ~w_eq;

    logic         r_gt;
    logic         r_eq;
    logic         r_lt;
    logic [W-1:0] r_max_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_gt       <= 1'b0;
            r_eq       <= 1'b0;
            r_lt       <= 1'b0;
            r_max_out  <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            // Flags drop on a bubble so they are never stale while idle.
            r_gt       <= r_s1_valid & w_gt;
            r_eq       <= r_s1_valid & w_eq;
            r_lt       <= r_s1_valid & w_lt;
            if (r_s1_valid) begin
                r_max_out <= (w_gt | w_eq) ? r_s1_a : r_s1_b;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign gt        = r_gt;
    assign eq        = r_eq;
    assign lt        = r_lt;
    assign max_out   = r_max_out;

    // ------------------------------------------------------------------
    // Running maximum
    // ------------------------------------------------------------------
`ifdef FLOP_CMP_RUNMAX_EN

    // Full single-cycle ordering of two values: returns a > b.
    function automatic logic f_greater(input logic [W-1:0] a,
                                       input logic [W-1:0] b);
        logic [c_MAG_W-1:0] ma;
        logic [c_MAG_W-1:0] mb;
        logic               res;
        ma  = a[c_MAG_W-1:0];
        mb  = b[c_MAG_W-1:0];
        res = 1'b0;
        if ((ma == '0) && (mb == '0)) begin
            res = 1'b0;
        end else if (a[W-1] != b[W-1]) begin
            res = ~a[W-1];
        end else if (ma == mb) begin
            res = 1'b0;
        end else begin
            res = (ma > mb) ^ a[W-1];
        end
        return res;
    endfunction

    logic         w_consume;
    logic [W-1:0] r_run_max;
    logic         r_run_max_valid;

    assign w_consume = r_s2_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset || max_clear) begin
            // Clear wins over a same-cycle update.
            r_run_max       <= '0;
            r_run_max_valid <= 1'b0;
        end else if (w_consume) begin
            if (!r_run_max_valid || f_greater(r_max_out, r_run_max)) begin
                r_run_max <= r_max_out;
            end
            r_run_max_valid <= 1'b1;
        end
    end

    assign run_max       = r_run_max;
    assign run_max_valid = r_run_max_valid;

`else

    logic w_unused_max_clear;

    assign w_unused_max_clear = max_clear;
    assign run_max            = '0;
    assign run_max_valid      = 1'b0;

`endif

endmodule
`default_nettype wire

// File: tb/tb_flop_compare_pipe.sv
`default_nettype none
//============================================================================
//  Module      : tb_flop_compare_pipe
//  Description : Self-checking bench for flop_compare_pipe. Accepted pairs
//                push a reference result into a queue; consumed results are
//                popped and compared. A reference running maximum follows
//                the consumed stream when FLOP_CMP_RUNMAX_EN is defined.
//  Revision    : 1.0 - initial release
//============================================================================
module tb_flop_compare_pipe;

    localparam int EXP_W = 4;
    localparam int MAN_W = 8;
    localparam int W     = 1 + EXP_W + MAN_W;

    typedef logic [W+2:0] exp_t;   // {gt, eq, lt, max_out}

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] first;
    logic [W-1:0] second;
    logic         out_valid;
    logic         out_ready;
    logic         gt;
    logic         eq;
    logic         lt;
    logic [W-1:0] max_out;
    logic         max_clear;
    logic [W-1:0] run_max;
    logic         run_max_valid;

    int total = 0;
    int bad   = 0;
    int n_out = 0;

    exp_t         sb[$];
    logic         stall = 1'b0;
    logic [W+3:0] held  = '0;
    logic         rm_valid_m = 1'b0;
    logic [W-1:0] rm_m = '0;

    flop_compare_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .first        (first),
        .second       (second),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .gt           (gt),
        .eq           (eq),
        .lt           (lt),
        .max_out      (max_out),
        .max_clear    (max_clear),
        .run_max      (run_max),
        .run_max_valid(run_max_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Signed integer value of an operand; +0 and -0 both map to 0.
    function automatic int sval(input logic [W-1:0] x);
        int m;
        m = int'(x[W-2:0]);
        return x[W-1] ? -m : m;
    endfunction

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        int va;
        int vb;
        va = sval(a);
        vb = sval(b);
        return {va > vb, va == vb, va < vb, (va >= vb) ? a : b};
    endfunction

    function automatic logic [W-1:0] rnd_op();
        logic [W-1:0] v;
        v = W'($urandom);
        if ($urandom_range(0, 3) == 0) v[W-2:0] = '0;
        return v;
    endfunction

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset) begin
            sb.delete();
            stall      = 1'b0;
            rm_valid_m = 1'b0;
            rm_m       = '0;
        end else begin
            check("run_max", {run_max_valid, run_max}, {rm_valid_m, rm_m});
            if (stall) check("hold", {out_valid, gt, eq, lt, max_out}, held);
            if (in_valid && in_ready) sb.push_back(model(first, second));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 32'd1, 32'd0);
                end else if (out_ready) begin
                    e = sb.pop_front();
                    check("result", {gt, eq, lt, max_out}, e);
                    n_out++;
`ifdef FLOP_CMP_RUNMAX_EN
                    if (!rm_valid_m || sval(e[W-1:0]) > sval(rm_m)) rm_m = e[W-1:0];
                    rm_valid_m = 1'b1;
`endif
                end
            end
`ifdef FLOP_CMP_RUNMAX_EN
            if (max_clear) begin
                rm_valid_m = 1'b0;
                rm_m       = '0;
            end
`endif
            stall = out_valid & ~out_ready;
            held  = {out_valid, gt, eq, lt, max_out};
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n        = 0;
        first    = a;
        second   = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            if (n >= 2) out_ready = 1'b1;
            n++;
            @(negedge clk);
        end
        if (!in_ready) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n         = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", sb.size(), 32'd0);
    endtask

    initial begin : main
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           base;
        int           n;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        max_clear = 1'b0;
        first     = '0;
        second    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 32'd0);
        check("rst_flags", {gt, eq, lt}, 32'd0);
        check("rst_max_out", max_out, 32'd0);
        check("rst_run_max", {run_max_valid, run_max}, 32'd0);
        reset = 1'b0;
        check("rst_in_ready", in_ready, 32'd1);

        // Latency: accept edge, then result after the following edge.
        send(13'h0420, 13'h0310);
        check("lat_early", out_valid, 32'd0);
        @(posedge clk); #1;
        check("lat_valid", out_valid, 32'd1);
        check("lat_gt", {gt, eq, lt}, 32'b100);
        check("lat_max", max_out, 32'h0420);

        // Directed sign/zero cases, back to back
        send(13'h1420, 13'h1310);
        send(13'h0000, 13'h1000);
        send(13'h0310, 13'h1310);
        send(13'h1420, 13'h1420);
        send(13'h1000, 13'h0001);
        send(13'h1000, 13'h1005);
        wait_drain();

        // Backpressure: two pairs fill the pipe, then in_ready drops.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        first = 13'h0420; second = 13'h0310;
        @(negedge clk); check("bp_rdy_p0", in_ready, 32'd1);
        @(posedge clk); #1;
        first = 13'h1420; second = 13'h1310;
        @(negedge clk); check("bp_rdy_p1", in_ready, 32'd1);
        @(posedge clk); #1;
        first = 13'h0000; second = 13'h1000;
        @(negedge clk); check("bp_rdy_p2", in_ready, 32'd0);
        @(posedge clk); #1;
        @(negedge clk); check("bp_rdy_p2b", in_ready, 32'd0);
        @(posedge clk); #1;
        base      = n_out;
        out_ready = 1'b1;
        send(13'h0000, 13'h1000);
        send(13'h0123, 13'h0456);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("bp_deliver_cnt", n_out - base, 32'd4);
        wait_drain();

        // Reset with pairs in flight discards them.
        send(13'h0111, 13'h0222);
        send(13'h0333, 13'h0444);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_valid", out_valid, 32'd0);
        check("mid_rst_flags", {gt, eq, lt}, 32'd0);
        check("mid_rst_max", max_out, 32'd0);
        reset = 1'b0;
        check("mid_rst_in_ready", in_ready, 32'd1);
        repeat (5) begin
            @(negedge clk);
            check("post_rst_idle", out_valid, 32'd0);
        end
        @(posedge clk); #1;

        // Running maximum sequence: consumed 0310, 1500, 0420
        send(13'h0310, 13'h0200);
        send(13'h1500, 13'h1600);
        send(13'h0420, 13'h0100);
        wait_drain();
        @(posedge clk); #1;
`ifdef FLOP_CMP_RUNMAX_EN
        check("rm_final", {run_max_valid, run_max}, {1'b1, 13'h0420});
`else
        check("rm_off", {run_max_valid, run_max}, 32'd0);
`endif
        // Clear pulse on the same edge as a consume
        send(13'h0111, 13'h0000);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("clr_wait", out_valid, 32'd1);
        max_clear = 1'b1;
        @(posedge clk); #1;
        max_clear = 1'b0;
        check("clr_run_max", {run_max_valid, run_max}, 32'd0);
        wait_drain();

        // Random traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            a = rnd_op();
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = {~a[W-1], a[W-2:0]};
                default: b = rnd_op();
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) max_clear = 1'b1;
            send(a, b);
            max_clear = 1'b0;
        end
        wait_drain();
        repeat (3) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/flop_compare_pipe.md
FLOP_COMPARE_PIPE -- requirements
Module: flop_compare_pipe

Interface
REQ-001 Parameter EXP_W, default 4: exponent field width in bits.
REQ-002 Parameter MAN_W, default 8: mantissa field width in bits.
REQ-003 Derived W = 1+EXP_W+MAN_W; bit W-1 is the sign, [W-2:MAN_W] is the exponent, [MAN_W-1:0] is the mantissa; the format is sign-magnitude.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  operand pair present.
REQ-007 in_ready  out  1  pipeline accepts the pair this cycle.
REQ-008 first  in  W  operand A.
REQ-009 second  in  W  operand B.
REQ-010 out_valid  out  1  result present.
REQ-011 out_ready  in  1  downstream consumes the result this cycle.
REQ-012 gt / eq / lt  out  1 each  A>B, A==B, A<B; exactly one is high while out_valid=1.
REQ-013 max_out  out  W  larger operand of the result pair (A when eq).
REQ-014 max_clear  in  1  synchronous clear of the running maximum.
REQ-015 run_max  out  W  running maximum of consumed max_out values.
REQ-016 run_max_valid  out  1  run_max holds at least one value.

Function
REQ-017 Magnitude {exp,man} SHALL be compared as an unsigned number of width EXP_W+MAN_W.
REQ-018 Zero magnitude SHALL equal zero magnitude regardless of sign (+0 == -0).
REQ-019 Otherwise: signs differ -> the positive operand is greater; both positive -> the larger magnitude is greater; both negative -> the smaller magnitude is greater; same sign and magnitude -> eq.
REQ-020 Stage 1 SHALL register the signs, a zero flag, the magnitude gt/eq flags and both operands; stage 2 SHALL register gt/eq/lt and max_out.
REQ-021 Latency SHALL be 2 cycles from the accept edge (in_valid&in_ready) to out_valid, with sustained throughput of 1 pair per cycle.
REQ-022 Stage 2 SHALL advance when it is empty or out_ready=1; stage 1 SHALL advance when stage 2 advances; in_ready SHALL be ~s1_valid | stage-1-advance (combinational).
REQ-023 While out_valid=1 and out_ready=0, all outputs SHALL hold stable; no pair is lost, duplicated or reordered.
REQ-024 Simultaneous accept and consume SHALL both take effect in the same cycle.
REQ-025 When out_valid & out_ready, run_max SHALL load max_out if run_max_valid=0 or max_out compares greater (REQ-017..019 rule) than run_max; run_max_valid SHALL then be set.
REQ-026 max_clear SHALL clear run_max and run_max_valid and take priority over a same-cycle update.

Reset
REQ-027 Reset SHALL clear both stage valid flags and force out_valid=0, gt=eq=lt=0, max_out=0, run_max=0, run_max_valid=0.
REQ-028 Reset during operation SHALL discard in-flight pairs; in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-029 Macro FLOP_CMP_RUNMAX_EN: when defined, REQ-025/026 are implemented.
REQ-030 Without FLOP_CMP_RUNMAX_EN, the ports remain present, run_max=0 and run_max_valid=0 constantly, max_clear is ignored, and no running-max registers are built.

Verification
REQ-031 first=13'h0420, second=13'h0310 -> after 2 cycles gt=1, max_out=13'h0420.
REQ-032 first=13'h1420, second=13'h1310 -> lt=1, max_out=13'h1310; first=13'h0000, second=13'h1000 -> eq=1, max_out=13'h0000.
REQ-033 out_ready=0, in_valid=1 for 4 cycles with pairs P0..P3 -> P0 and P1 accepted, then in_ready=0; out_ready=1 -> P0, P1, P2, P3 delivered in order, one per cycle.
REQ-034 Reset asserted 1 cycle after accepting 2 pairs -> out_valid stays 0 afterwards, and no stale result appears.
REQ-035 RUNMAX_EN: consumed max_out 13'h0310, 13'h1500, 13'h0420 -> run_max = 13'h0310, 13'h0310, 13'h0420; max_clear pulse coinciding with a consume -> run_max=0, run_max_valid=0.
